// File: rtl/cpu_serial_arbiter_if.sv
// Requester-side bus of the CPU serial arbiter: two parallel command ports
// plus the shared valid/ready response channel.
interface cpu_serial_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4
);
   logic [1:0]        req_valid;
   logic [DATA_W-1:0] req_a0;
   logic [DATA_W-1:0] req_b0;
   logic [OP_W-1:0]   req_op0;
   logic [DATA_W-1:0] req_a1;
   logic [DATA_W-1:0] req_b1;
   logic [OP_W-1:0]   req_op1;
   logic [1:0]        req_ready;
   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic [3:0]        resp_flags;

   modport master (
      output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_flags
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
      output req_ready, resp_valid, resp_data, resp_flags
   );
endinterface

// File: rtl/cpu_serial_arbiter.sv
// Round-robin arbiter sharing the CPU serial command port between two requesters:
// start pulse, MSB-first A/B/opcode stream, fixed result latency, valid/ready return.
module cpu_serial_arbiter #(
   parameter int DATA_W     = 8,
   parameter int OP_W       = 4,
   parameter int RESULT_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   cpu_serial_arbiter_if.slave bus,
   output logic              cpu_start,
   output logic              cpu_serial,
   input  logic [DATA_W-1:0] cpu_result,
   input  logic [3:0]        cpu_flags,
   output logic              busy,
   output logic              grant_id
);

   localparam int SR_W    = 2*DATA_W + OP_W;
   localparam int MAX_AB  = (DATA_W > OP_W) ? DATA_W : OP_W;
   localparam int MAX_LEN = (MAX_AB > RESULT_LAT) ? MAX_AB : RESULT_LAT;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SHIFT_A, S_SHIFT_B, S_SHIFT_OP, S_WAIT, S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [SR_W-1:0]   r_sr;
   logic              r_last_grant;
   logic              r_grant_id;
   logic              r_cpu_start;
   logic              r_cpu_serial;
   logic [DATA_W-1:0] r_resp_data;
   logic [3:0]        r_resp_flags;
   logic              w_grant;
   logic              w_grant_fire;
   logic              w_next_is_shift;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_grant      = r_last_grant;
      w_grant_fire = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.req_valid != 2'b00) begin
               w_grant_fire = 1'b1;
               w_next_state = S_START;
               case (bus.req_valid)
                  2'b01:   w_grant = 1'b0;
                  2'b10:   w_grant = 1'b1;
                  default: w_grant = ~r_last_grant;
               endcase
            end
         end
         S_START:    w_next_state = S_SHIFT_A;
         S_SHIFT_A:  if (r_cnt == CNT_W'(DATA_W-1))     w_next_state = S_SHIFT_B;
         S_SHIFT_B:  if (r_cnt == CNT_W'(DATA_W-1))     w_next_state = S_SHIFT_OP;
         S_SHIFT_OP: if (r_cnt == CNT_W'(OP_W-1))       w_next_state = S_WAIT;
         S_WAIT:     if (r_cnt == CNT_W'(RESULT_LAT-1)) w_next_state = S_RESP;
         S_RESP:     if (bus.resp_ready[r_grant_id])    w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   assign w_next_is_shift = (w_next_state == S_SHIFT_A) || (w_next_state == S_SHIFT_B) ||
                            (w_next_state == S_SHIFT_OP);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state)
            r_cnt <= '0;
         else if (r_state != S_IDLE && r_state != S_RESP)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Serial outputs are computed from the next state so the pins come straight off flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr         <= '0;
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_cpu_start  <= 1'b0;
         r_cpu_serial <= 1'b0;
         r_resp_data  <= '0;
         r_resp_flags <= '0;
      end else begin
         r_cpu_start <= (w_next_state == S_START);
         if (w_grant_fire) begin
            r_sr         <= w_grant ? {bus.req_a1, bus.req_b1, bus.req_op1}
                                    : {bus.req_a0, bus.req_b0, bus.req_op0};
            r_grant_id   <= w_grant;
            r_last_grant <= w_grant;
            r_cpu_serial <= 1'b0;
         end else if (w_next_is_shift) begin
            r_cpu_serial <= r_sr[SR_W-1];
            r_sr         <= r_sr << 1;
         end else begin
            r_cpu_serial <= 1'b0;
         end
         if (r_state == S_WAIT && w_next_state == S_RESP) begin
            r_resp_data  <= cpu_result;
            r_resp_flags <= cpu_flags;
         end
      end
   end

   assign bus.req_ready  = w_grant_fire ? (2'b01 << w_grant) : 2'b00;
   assign bus.resp_valid = (r_state == S_RESP) ? (2'b01 << r_grant_id) : 2'b00;
   assign bus.resp_data  = r_resp_data;
   assign bus.resp_flags = r_resp_flags;
   assign cpu_start      = r_cpu_start;
   assign cpu_serial     = r_cpu_serial;
   assign busy           = (r_state != S_IDLE);
   assign grant_id       = r_grant_id;

endmodule
